// File: rtl/seq_divider_if.sv
// Handshake and operand bus between the control unit and the iterative divider.
interface seq_divider_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (
      output start, op, dividend, divisor,
      input  busy, done, result
   );

   modport slave (
      input  start, op, dividend, divisor,
      output busy, done, result
   );
endinterface

// File: rtl/seq_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per clock,
// fixed WIDTH+1 cycle latency from accepted start to the done pulse.
module seq_divider #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   seq_divider_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t r_state;
   state_t w_nextState;

   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_divAbs;
   logic [WIDTH-1:0] r_result;
   logic [CNT_W-1:0] r_count;
   logic             r_qNeg;
   logic             r_rNeg;
   logic             r_isRem;
   logic             r_divZero;
   logic             r_done;

   logic             w_signedOp;
   logic             w_dividendNeg;
   logic             w_divisorNeg;
   logic [WIDTH-1:0] w_dividendAbs;
   logic [WIDTH-1:0] w_divisorAbs;
   logic [WIDTH:0]   w_remShift;
   logic [WIDTH:0]   w_trial;
   logic [WIDTH-1:0] w_quoFinal;
   logic [WIDTH-1:0] w_remFinal;

   // Operand conditioning: signed ops work on magnitudes; the most-negative value
   // negates to itself, which reads correctly as unsigned 2^(WIDTH-1).
   assign w_signedOp    = ~bus.op[0];
   assign w_dividendNeg = w_signedOp & bus.dividend[WIDTH-1];
   assign w_divisorNeg  = w_signedOp & bus.divisor[WIDTH-1];
   assign w_dividendAbs = w_dividendNeg ? -bus.dividend : bus.dividend;
   assign w_divisorAbs  = w_divisorNeg ? -bus.divisor : bus.divisor;

   // One restoring step: shift the next dividend bit into the partial remainder
   // and try to subtract the divisor with one extra bit to catch the borrow.
   assign w_remShift = {r_rem, r_quo[WIDTH-1]};
   assign w_trial    = w_remShift - {1'b0, r_divAbs};

   // Sign fix-up; divide-by-zero forces an all-ones quotient regardless of signs,
   // while the remainder path naturally restores the original dividend.
   assign w_quoFinal = r_divZero ? {WIDTH{1'b1}} : (r_qNeg ? -r_quo : r_quo);
   assign w_remFinal = r_rNeg ? -r_rem : r_rem;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: IDLE -> CALC on start, WIDTH iterations, one FIN cycle
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: if (bus.start) w_nextState = CALC;
         CALC: if (r_count == CNT_W'(1)) w_nextState = FIN;
         FIN:  w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Outputs: busy follows the state, done and result come from registers
   always_comb begin
      bus.busy   = (r_state != IDLE);
      bus.done   = r_done;
      bus.result = r_result;
   end

   // Datapath: latch operands on start, iterate in CALC, register the result in FIN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rem     <= '0;
         r_quo     <= '0;
         r_divAbs  <= '0;
         r_result  <= '0;
         r_count   <= '0;
         r_qNeg    <= 1'b0;
         r_rNeg    <= 1'b0;
         r_isRem   <= 1'b0;
         r_divZero <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_rem     <= '0;
                  r_quo     <= w_dividendAbs;
                  r_divAbs  <= w_divisorAbs;
                  r_qNeg    <= w_dividendNeg ^ w_divisorNeg;
                  r_rNeg    <= w_dividendNeg;
                  r_isRem   <= bus.op[1];
                  r_divZero <= (bus.divisor == '0);
                  r_count   <= CNT_W'(WIDTH);
               end
            end
            CALC: begin
               if (!w_trial[WIDTH]) begin
                  r_rem <= w_trial[WIDTH-1:0];
                  r_quo <= {r_quo[WIDTH-2:0], 1'b1};
               end else begin
                  r_rem <= w_remShift[WIDTH-1:0];
                  r_quo <= {r_quo[WIDTH-2:0], 1'b0};
               end
               r_count <= r_count - CNT_W'(1);
            end
            FIN: begin
               r_result <= r_isRem ? w_remFinal : w_quoFinal;
            end
            default: begin
               r_count <= '0;
            end
         endcase
      end
   end

   // Done pulses for exactly the cycle after FIN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done <= 1'b0;
      end else begin
         r_done <= (r_state == FIN);
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases with literal results plus
// randomized traffic compared every cycle against an arithmetic reference model.
module tb_seq_divider;

   localparam int WIDTH   = 32;
   localparam int LATENCY = WIDTH + 1;

   logic clk;
   logic rst_n;
   bit   checkEn;
   int   compared;
   int   mismatched;

   seq_divider_if #(.WIDTH(WIDTH)) bus ();

   seq_divider #(.WIDTH(WIDTH), .CNT_W(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running clock, 10 time units per period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected result from plain RISC-V M-extension arithmetic rules
   function automatic logic [31:0] refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q;
      logic [31:0] r;
      if (b == 32'd0) begin
         q = 32'hFFFFFFFF;
         r = a;
      end else if (op[0]) begin
         q = a / b;
         r = a % b;
      end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
         q = 32'h80000000;
         r = 32'd0;
      end else begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end
      return op[1] ? r : q;
   endfunction

   // Operand generator biased toward the corner values of division
   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 6))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: an accepted request yields its result LATENCY edges later
   logic        mBusy;
   logic        mDone;
   logic [31:0] mResult;
   logic [31:0] mPending;
   int          mRemaining;

   // Model update on each clock edge, cleared immediately by reset
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mBusy      <= 1'b0;
         mDone      <= 1'b0;
         mResult    <= 32'd0;
         mPending   <= 32'd0;
         mRemaining <= 0;
      end else begin
         mDone <= 1'b0;
         if (mBusy) begin
            if (mRemaining == 1) begin
               mBusy   <= 1'b0;
               mDone   <= 1'b1;
               mResult <= mPending;
            end
            mRemaining <= mRemaining - 1;
         end else if (bus.start) begin
            mBusy      <= 1'b1;
            mRemaining <= LATENCY;
            mPending   <= refModel(bus.op, bus.dividend, bus.divisor);
         end
      end
   end

   // Compare DUT against the model on every falling edge
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("busy", 32'(bus.busy), 32'(mBusy));
         checkOutput("done", 32'(bus.done), 32'(mDone));
         checkOutput("result", bus.result, mResult);
      end
   end

   // Present one request for a single cycle, then scramble the inputs
   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.start    = 1'b1;
      bus.op       = op;
      bus.dividend = a;
      bus.divisor  = b;
      @(posedge clk);
      #1;
      bus.start    = 1'b0;
      bus.op       = 2'($urandom);
      bus.dividend = $urandom;
      bus.divisor  = $urandom;
   endtask

   // Bounded wait for done; returns at the falling edge where done is seen
   task automatic waitDone(output int busyCycles, output int edges, output bit seen);
      busyCycles = 0;
      edges      = 0;
      seen       = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         edges++;
         if (bus.done) seen = 1'b1;
         else if (bus.busy) busyCycles++;
      end
   endtask

   task automatic runCheck(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] expected);
      int  busyCycles;
      int  edges;
      bit  seen;
      applyStimulus(op, a, b);
      waitDone(busyCycles, edges, seen);
      checkOutput({name, "_done"}, 32'(seen), 32'd1);
      checkOutput({name, "_latency"}, 32'(edges - 1), 32'(LATENCY));
      checkOutput({name, "_busyCycles"}, 32'(busyCycles), 32'(LATENCY));
      checkOutput({name, "_result"}, bus.result, expected);
   endtask

   initial begin
      int  busyCycles;
      int  edges;
      bit  seen;
      int  doneCount;

      compared     = 0;
      mismatched   = 0;
      checkEn      = 1'b0;
      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.op       = 2'b00;
      bus.dividend = 32'd0;
      bus.divisor  = 32'd0;

      checkOutput("pin_div_neg", refModel(2'b00, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFD);
      checkOutput("pin_rem_neg", refModel(2'b10, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);
      checkOutput("pin_div_ovf", refModel(2'b00, 32'h80000000, 32'hFFFFFFFF), 32'h80000000);
      checkOutput("pin_divu_100_7", refModel(2'b01, 32'd100, 32'd7), 32'd14);
      checkOutput("pin_rem_by0", refModel(2'b10, 32'hFFFFFFF9, 32'd0), 32'hFFFFFFF9);

      repeat (2) @(posedge clk);
      checkEn = 1'b1;
      @(negedge clk);
      checkOutput("reset_busy", 32'(bus.busy), 32'd0);
      checkOutput("reset_done", 32'(bus.done), 32'd0);
      checkOutput("reset_result", bus.result, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      runCheck("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14);
      runCheck("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2);
      runCheck("div_m7_2", 2'b00, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
      runCheck("rem_m7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
      runCheck("div_ovf", 2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
      runCheck("rem_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0);
      runCheck("divu_by0", 2'b01, 32'd5, 32'd0, 32'hFFFFFFFF);
      runCheck("remu_by0", 2'b11, 32'd5, 32'd0, 32'd5);
      runCheck("div_by0", 2'b00, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF);
      runCheck("rem_by0", 2'b10, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9);

      applyStimulus(2'b01, 32'd1000, 32'd10);
      repeat (4) @(negedge clk);
      @(posedge clk);
      #1;
      bus.start    = 1'b1;
      bus.op       = 2'b01;
      bus.dividend = 32'd9;
      bus.divisor  = 32'd3;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      waitDone(busyCycles, edges, seen);
      checkOutput("ignored_start_done", 32'(seen), 32'd1);
      checkOutput("ignored_start_result", bus.result, 32'd100);
      runCheck("back_to_back_9_3", 2'b01, 32'd9, 32'd3, 32'd3);

      applyStimulus(2'b01, 32'd100, 32'd7);
      repeat (10) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_busy", 32'(bus.busy), 32'd0);
      checkOutput("abort_done", 32'(bus.done), 32'd0);
      checkOutput("abort_result", bus.result, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      doneCount = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) doneCount++;
      end
      checkOutput("abort_no_done", 32'(doneCount), 32'd0);
      runCheck("after_abort_8_2", 2'b01, 32'd8, 32'd2, 32'd4);

      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #1;
         bus.start    = ($urandom_range(0, 3) == 0);
         bus.op       = 2'($urandom);
         bus.dividend = pickOperand();
         bus.divisor  = pickOperand();
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (LATENCY + 5) @(posedge clk);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
